// File: rtl/dht_pkg.sv
// Shared constants for the DHT read scheduler: FSM state encodings,
// error codes, default timing in 50 MHz cycles and a counter-width helper.
package dht_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HOLD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;

  // Cause of the last failed attempt
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CKS  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // Default timing at 50 MHz
  localparam int DEF_MIN_GAP_CYC     = 100_000_000;
  localparam int DEF_TIMEOUT_CYC     = 1_500_000;
  localparam int DEF_MAX_RETRY       = 3;
  localparam int DEF_AUTO_PERIOD_CYC = 250_000_000;

  // Width that holds the largest of three cycle counts
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dht_sat_counter.sv
// Saturating up-counter with synchronous clear and an at-limit flag.
// Clear takes priority over enable.
module dht_sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIM = LIMIT[WIDTH-1:0];

  logic [WIDTH-1:0] count;

  // Count up until the limit, then hold there until cleared
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIM)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_limit = (count == LIM);

endmodule

// File: rtl/dht_read_scheduler.sv
// Sequences read transactions on the single-wire DHT reader: enforces the
// minimum interval between start pulses, times out each attempt, checks the
// checksum, retries failures and holds the last good reading.
// Optional periodic auto-read is enabled by defining DHT_SCHED_AUTO_EN.
module dht_read_scheduler
  import dht_pkg::*;
#(
  parameter int MIN_GAP_CYC = DEF_MIN_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
`ifdef DHT_SCHED_AUTO_EN
  ,
  parameter int AUTO_PERIOD_CYC = DEF_AUTO_PERIOD_CYC
`endif
) (
  input  logic       clk_50M,
  input  logic       reset,
`ifdef DHT_SCHED_AUTO_EN
  input  logic       auto_en_i,
`endif
  input  logic       req_i,
  output logic       busy_o,
  output logic       rd_start_o,
  input  logic       rd_valid_i,
  input  logic [7:0] rd_rh_int_i,
  input  logic [7:0] rd_rh_dec_i,
  input  logic [7:0] rd_t_int_i,
  input  logic [7:0] rd_t_dec_i,
  input  logic [7:0] rd_cks_i,
  output logic [7:0] rh_int_o,
  output logic [7:0] rh_dec_o,
  output logic [7:0] t_int_o,
  output logic [7:0] t_dec_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic [1:0] retry_cnt_o
);

`ifdef DHT_SCHED_AUTO_EN
  localparam int CNT_W = cnt_width(MIN_GAP_CYC, TIMEOUT_CYC, AUTO_PERIOD_CYC);
`else
  localparam int CNT_W = cnt_width(MIN_GAP_CYC, TIMEOUT_CYC, 0);
`endif

  logic [2:0] state;
  logic       pending;
  logic [7:0] stg_rh_int, stg_rh_dec, stg_t_int, stg_t_dec, stg_cks;
  logic [7:0] cks_sum;
  logic       cks_good;
  logic       gap_ok, tmo_hit, ext_req;
  logic       in_start, in_wait;
  logic       attempt_fail;
  logic [1:0] fail_code;

  assign in_start   = (state == ST_START);
  assign in_wait    = (state == ST_WAIT);
  assign rd_start_o = in_start && !reset;
  assign busy_o     = (state != ST_IDLE) && !reset;
  assign cks_sum    = stg_rh_int + stg_rh_dec + stg_t_int + stg_t_dec;
  assign cks_good   = (cks_sum == stg_cks);

  dht_sat_counter #(.WIDTH(CNT_W), .LIMIT(MIN_GAP_CYC)) u_gap_cnt (
    .clk      (clk_50M),
    .reset    (reset),
    .clear    (in_start),
    .enable   (1'b1),
    .at_limit (gap_ok)
  );

  dht_sat_counter #(.WIDTH(CNT_W), .LIMIT(TIMEOUT_CYC)) u_tmo_cnt (
    .clk      (clk_50M),
    .reset    (reset),
    .clear    (in_start),
    .enable   (in_wait),
    .at_limit (tmo_hit)
  );

`ifdef DHT_SCHED_AUTO_EN
  logic auto_hit;
  logic auto_clear;

  assign auto_clear = !auto_en_i || auto_hit;

  dht_sat_counter #(.WIDTH(CNT_W), .LIMIT(AUTO_PERIOD_CYC - 1)) u_auto_cnt (
    .clk      (clk_50M),
    .reset    (reset),
    .clear    (auto_clear),
    .enable   (auto_en_i),
    .at_limit (auto_hit)
  );

  assign ext_req = req_i || (auto_en_i && auto_hit);
`else
  assign ext_req = req_i;
`endif

  // Decide whether the current attempt has failed and why
  always_comb begin
    attempt_fail = 1'b0;
    fail_code    = ERR_NONE;
    if (in_wait && !rd_valid_i && tmo_hit) begin
      attempt_fail = 1'b1;
      fail_code    = ERR_TMO;
    end else if ((state == ST_CHECK) && !cks_good) begin
      attempt_fail = 1'b1;
      fail_code    = ERR_CKS;
    end
  end

  // Transaction FSM, pending request flag, staging and output registers
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      stg_rh_int  <= '0;
      stg_rh_dec  <= '0;
      stg_t_int   <= '0;
      stg_t_dec   <= '0;
      stg_cks     <= '0;
      rh_int_o    <= '0;
      rh_dec_o    <= '0;
      t_int_o     <= '0;
      t_dec_o     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      retry_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (ext_req && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (ext_req || pending) begin
            state       <= ST_HOLD;
            pending     <= 1'b0;
            retry_cnt_o <= '0;
            err_code_o  <= ERR_NONE;
          end
        end
        ST_HOLD: begin
          if (gap_ok) state <= ST_START;
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rd_valid_i) begin
            stg_rh_int <= rd_rh_int_i;
            stg_rh_dec <= rd_rh_dec_i;
            stg_t_int  <= rd_t_int_i;
            stg_t_dec  <= rd_t_dec_i;
            stg_cks    <= rd_cks_i;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cks_good) begin
            rh_int_o <= stg_rh_int;
            rh_dec_o <= stg_rh_dec;
            t_int_o  <= stg_t_int;
            t_dec_o  <= stg_t_dec;
            done_o   <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (attempt_fail) begin
        err_code_o <= fail_code;
        if (int'(retry_cnt_o) < MAX_RETRY) begin
          retry_cnt_o <= retry_cnt_o + 2'd1;
          state       <= ST_HOLD;
        end else begin
          err_o <= 1'b1;
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht_read_scheduler.sv
// Directed testbench for dht_read_scheduler with small timing parameters.
// Build with DHT_SCHED_AUTO_EN defined to also exercise periodic auto-read.
module tb_dht_read_scheduler;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       req_i;
  logic       busy_o, rd_start_o, rd_valid_i;
  logic [7:0] rd_rh_int_i, rd_rh_dec_i, rd_t_int_i, rd_t_dec_i, rd_cks_i;
  logic [7:0] rh_int_o, rh_dec_o, t_int_o, t_dec_o;
  logic       done_o, err_o;
  logic [1:0] err_code_o, retry_cnt_o;
`ifdef DHT_SCHED_AUTO_EN
  logic       auto_en_i = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc         = 0;
  int n_starts    = 0;
  int n_done      = 0;
  int n_err       = 0;
  int n_both      = 0;
  int n_rst_start = 0;
  int last_start  = -1;
  int last_space  = 0;
  int min_space   = 1000000;

  dht_read_scheduler #(
    .MIN_GAP_CYC (100),
    .TIMEOUT_CYC (50),
    .MAX_RETRY   (2)
`ifdef DHT_SCHED_AUTO_EN
    ,
    .AUTO_PERIOD_CYC (400)
`endif
  ) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
`ifdef DHT_SCHED_AUTO_EN
    .auto_en_i   (auto_en_i),
`endif
    .req_i       (req_i),
    .busy_o      (busy_o),
    .rd_start_o  (rd_start_o),
    .rd_valid_i  (rd_valid_i),
    .rd_rh_int_i (rd_rh_int_i),
    .rd_rh_dec_i (rd_rh_dec_i),
    .rd_t_int_i  (rd_t_int_i),
    .rd_t_dec_i  (rd_t_dec_i),
    .rd_cks_i    (rd_cks_i),
    .rh_int_o    (rh_int_o),
    .rh_dec_o    (rh_dec_o),
    .t_int_o     (t_int_o),
    .t_dec_o     (t_dec_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .retry_cnt_o (retry_cnt_o)
  );

  always #10 clk_50M = ~clk_50M;

  // Cycle-level monitor: start pulse spacing and done/err pulse counts
  always @(negedge clk_50M) begin
    cyc = cyc + 1;
    if (reset && rd_start_o) n_rst_start = n_rst_start + 1;
    if (rd_start_o) begin
      n_starts = n_starts + 1;
      if (last_start >= 0) begin
        last_space = cyc - last_start;
        if (last_space < min_space) min_space = last_space;
      end
      last_start = cyc;
    end
    if (done_o) n_done = n_done + 1;
    if (err_o) n_err = n_err + 1;
    if (done_o && err_o) n_both = n_both + 1;
  end

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run = tests_run + 1;
    assert (observed === expected)
    else begin
      tests_failed = tests_failed + 1;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pulseReq();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
  endtask

  task automatic waitStart(input string tag, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rd_start_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(tag, found, 1);
  endtask

  // Present one reader result for a single cycle, end two cycles later
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d,
                               input logic [7:0] k);
    rd_rh_int_i = a;
    rd_rh_dec_i = b;
    rd_t_int_i  = c;
    rd_t_dec_i  = d;
    rd_cks_i    = k;
    rd_valid_i  = 1'b1;
    tick();
    rd_valid_i  = 1'b0;
    tick();
  endtask

  initial begin
    int rel_cyc, s0, d0, e0, waited;
    bit err_seen;

    reset = 1'b1;
    req_i = 1'b0;
    rd_valid_i = 1'b0;
    rd_rh_int_i = '0; rd_rh_dec_i = '0; rd_t_int_i = '0; rd_t_dec_i = '0; rd_cks_i = '0;
    repeat (3) tick();

    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_start", rd_start_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_rh_int", rh_int_o, 0);
    checkOutput("rst_err_code", err_code_o, 0);
    checkOutput("rst_retry", retry_cnt_o, 0);

    // First read: power-up hold-off, good checksum
    reset = 1'b0;
    rel_cyc = cyc;
    repeat (10) tick();
    pulseReq();
    checkOutput("busy_rise", busy_o, 1);
    checkOutput("no_early_start", rd_start_o, 0);
    waitStart("start1_seen", 300);
    checkOutput("holdoff_ge_100", (cyc - rel_cyc) >= 100, 1);
    repeat (3) tick();
    applyStimulus(8'd55, 8'd15, 8'd23, 8'd5, 8'd98);
    checkOutput("t1_done", done_o, 1);
    checkOutput("t1_rh_int", rh_int_o, 55);
    checkOutput("t1_rh_dec", rh_dec_o, 15);
    checkOutput("t1_t_int", t_int_o, 23);
    checkOutput("t1_t_dec", t_dec_o, 5);
    checkOutput("t1_busy_low", busy_o, 0);
    checkOutput("t1_err_code", err_code_o, 0);
    checkOutput("t1_retry", retry_cnt_o, 0);
    tick();
    checkOutput("t1_done_one_cycle", done_o, 0);

    // Two bad checksums then a good one
    pulseReq();
    for (int a = 0; a < 3; a++) begin
      waitStart("t2_start_seen", 300);
      repeat (2) tick();
      if (a < 2) begin
        applyStimulus(8'd30, 8'd5, 8'd29, 8'd1, 8'd64);
        checkOutput("t2_retry_step", retry_cnt_o, a + 1);
        checkOutput("t2_busy_retry", busy_o, 1);
        checkOutput("t2_no_done", done_o, 0);
        checkOutput("t2_err_code_cks", err_code_o, 1);
      end else begin
        applyStimulus(8'd30, 8'd5, 8'd29, 8'd1, 8'd65);
      end
    end
    checkOutput("t2_done", done_o, 1);
    checkOutput("t2_retry", retry_cnt_o, 2);
    checkOutput("t2_rh_int", rh_int_o, 30);
    checkOutput("t2_rh_dec", rh_dec_o, 5);
    checkOutput("t2_t_int", t_int_o, 29);
    checkOutput("t2_t_dec", t_dec_o, 1);
    checkOutput("t2_err_code_last", err_code_o, 1);
    checkOutput("t2_min_spacing", min_space >= 100, 1);

    // Reader never answers: three timeouts then err_o
    s0 = n_starts;
    e0 = n_err;
    pulseReq();
    for (int a = 0; a < 3; a++) begin
      waitStart("t3_start_seen", 300);
      if (a < 2) tick();
    end
    err_seen = 1'b0;
    waited = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (err_o) begin
        err_seen = 1'b1;
        waited = i;
        break;
      end
    end
    checkOutput("t3_err_seen", err_seen, 1);
    checkOutput("t3_timeout_len", (waited >= 50) && (waited <= 53), 1);
    checkOutput("t3_starts", n_starts - s0, 3);
    checkOutput("t3_err_code", err_code_o, 2);
    checkOutput("t3_retry", retry_cnt_o, 2);
    checkOutput("t3_done_low", done_o, 0);
    checkOutput("t3_keep_rh_int", rh_int_o, 30);
    checkOutput("t3_keep_t_int", t_int_o, 29);
    checkOutput("t3_keep_t_dec", t_dec_o, 1);
    tick();
    checkOutput("t3_err_count", n_err - e0, 1);

    // Three requests while busy collapse into one extra transaction
    s0 = n_starts;
    d0 = n_done;
    pulseReq();
    for (int r = 0; r < 3; r++) begin
      repeat (5) tick();
      pulseReq();
    end
    waitStart("t4_start1_seen", 300);
    repeat (2) tick();
    applyStimulus(8'd10, 8'd20, 8'd30, 8'd40, 8'd100);
    checkOutput("t4_done1", done_o, 1);
    waitStart("t4_start2_seen", 300);
    repeat (2) tick();
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 8'd10);
    checkOutput("t4_done2", done_o, 1);
    checkOutput("t4_rh_int", rh_int_o, 1);
    checkOutput("t4_t_dec", t_dec_o, 4);
    repeat (300) tick();
    checkOutput("t4_starts", n_starts - s0, 2);
    checkOutput("t4_dones", n_done - d0, 2);
    checkOutput("t4_idle", busy_o, 0);

    // Reset in WAIT together with a valid reading
    d0 = n_done;
    pulseReq();
    waitStart("t5_start_seen", 300);
    repeat (3) tick();
    rd_rh_int_i = 8'd9; rd_rh_dec_i = 8'd9; rd_t_int_i = 8'd9; rd_t_dec_i = 8'd9;
    rd_cks_i = 8'd36;
    rd_valid_i = 1'b1;
    reset = 1'b1;
    tick();
    rd_valid_i = 1'b0;
    checkOutput("t5_rh_int", rh_int_o, 0);
    checkOutput("t5_rh_dec", rh_dec_o, 0);
    checkOutput("t5_t_int", t_int_o, 0);
    checkOutput("t5_t_dec", t_dec_o, 0);
    checkOutput("t5_busy", busy_o, 0);
    checkOutput("t5_start", rd_start_o, 0);
    checkOutput("t5_err_code", err_code_o, 0);
    checkOutput("t5_retry", retry_cnt_o, 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checkOutput("t5_no_done", n_done - d0, 0);
    checkOutput("t5_idle_after", busy_o, 0);
    checkOutput("t5_out_still_0", rh_int_o, 0);

`ifdef DHT_SCHED_AUTO_EN
    // Periodic auto-read every 400 cycles, stops when disabled
    auto_en_i = 1'b1;
    waitStart("auto_start1_seen", 900);
    repeat (2) tick();
    applyStimulus(8'd1, 8'd1, 8'd1, 8'd1, 8'd4);
    waitStart("auto_start2_seen", 900);
    checkOutput("auto_period", last_space, 400);
    repeat (2) tick();
    applyStimulus(8'd2, 8'd2, 8'd2, 8'd2, 8'd8);
    auto_en_i = 1'b0;
    s0 = n_starts;
    repeat (900) tick();
    checkOutput("auto_stopped", n_starts - s0, 0);
`endif

    checkOutput("never_done_and_err", n_both, 0);
    checkOutput("no_start_in_reset", n_rst_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dht_read_scheduler.md
# dht_read_scheduler

Sequences read transactions on the `t2a_dht` single-wire DHT reader, between user logic and the reader on the 50 MHz domain.
- Issues start pulses to the reader, never more often than the sensor's minimum interval.
- Bounds each attempt with a timeout, verifies the checksum and retries failed attempts.
- Holds the last good reading stable for downstream consumers.

## Interface
- MIN_GAP_CYC, 100_000_000, minimum cycles between consecutive rd_start_o pulses (2 s); also the power-up hold-off after reset
- TIMEOUT_CYC, 1_500_000, cycles after rd_start_o within which rd_valid_i must arrive (30 ms)
- MAX_RETRY, 3, retries after the first failed attempt; the number of attempts is MAX_RETRY+1
- clk_50M  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- req_i  in  1  single-cycle read request
- busy_o  out  1  high from request acceptance until done_o/err_o
- rd_start_o  out  1  one-cycle start pulse to reader
- rd_valid_i  in  1  reader data_valid
- rd_rh_int_i, rd_rh_dec_i, rd_t_int_i, rd_t_dec_i, rd_cks_i  in  8 each  reader bytes
- rh_int_o, rh_dec_o, t_int_o, t_dec_o  out  8 each  last good reading
- done_o  out  1  one-cycle pulse, good reading latched
- err_o  out  1  one-cycle pulse, all attempts failed
- err_code_o  out  2  00 none, 01 checksum, 10 timeout (cause of last failed attempt)
- retry_cnt_o  out  2  number of retries used in current/last transaction

## Operation
- States: IDLE, HOLD (wait for the gap), START, WAIT, CHECK.
- gap_cnt:
  - Saturating up-counter.
  - Cleared by reset and by every rd_start_o.
  - The gap is satisfied when gap_cnt == MIN_GAP_CYC.
- IDLE:
  - A request (req_i, or a pending flag) moves to HOLD.
  - busy_o rises in the same cycle as the move.
  - retry_cnt_o and err_code_o are cleared.
- HOLD: goes to START once the gap is satisfied. Retries also pass through HOLD, so every attempt honours MIN_GAP_CYC.
- START: rd_start_o=1 for exactly one cycle, the timeout counter clears, then WAIT.
- WAIT:
  - rd_valid_i captures all five bytes into staging registers, then CHECK.
  - If the timeout counter reaches TIMEOUT_CYC first, the attempt fails with code 10.
  - If rd_valid_i and the timeout occur in the same cycle, the valid wins.
- CHECK: good when (rh_int+rh_dec+t_int+t_dec) mod 256 == cks, an 8-bit wrap sum.
  - Good: copy the staging registers to the outputs, pulse done_o, go to IDLE.
  - Bad: failure with code 01.
- Failure:
  - If retries used < MAX_RETRY: increment retry_cnt_o and go to HOLD.
  - Otherwise: pulse err_o and go to IDLE. The output bytes stay unchanged.
- rd_valid_i outside WAIT is ignored.
- req_i while busy sets a one-deep pending flag; further requests are dropped. The pending flag is serviced on return to IDLE.
- A req_i in the same cycle as done_o/err_o is also latched as pending.
- Reset, including mid-transaction:
  - Every output is 0.
  - State goes to IDLE.
  - The pending flag and all counters clear.
  - rd_start_o is never asserted during reset.

## Timing
- req_i at cycle n (IDLE, gap satisfied): busy_o=1 at n+1, rd_start_o=1 at n+2.
- rd_valid_i at cycle m: done_o or a retry decision at m+2 (m+1 CHECK).
- Outputs update in the same cycle done_o is high; done_o and err_o are never high together.
- First read after reset: rd_start_o no earlier than MIN_GAP_CYC cycles after reset deasserts.
- Counter widths are $clog2 of the largest parameter + 1.

## Configuration
- DHT_SCHED_AUTO_EN defined:
  - Adds parameter AUTO_PERIOD_CYC (default 250_000_000, 5 s) and input auto_en_i (1 bit).
  - While auto_en_i=1, a free-running period counter raises an internal request every AUTO_PERIOD_CYC cycles. The request is handled exactly like req_i, including the pending rule.
  - Clearing auto_en_i resets the period counter.
- Undefined: no port, no counter; reads occur only on req_i.

## Structure
- dht_pkg holds:
  - the state enum;
  - the err_code localparams ERR_NONE/ERR_CKS/ERR_TMO;
  - the default timing constants in cycles at 50 MHz.
- One sub-module, dht_sat_counter (parameterised width/limit, clear, enable, at_limit flag). It is instantiated for gap_cnt, the timeout counter and the auto period counter.

## Test plan
Bench parameters: MIN_GAP_CYC=100, TIMEOUT_CYC=50, MAX_RETRY=2.

- Reset, req_i at cycle 10 → rd_start_o only at cycle ≥100 after reset release. Reader returns 55,15,23,5,98 → done_o, and outputs read 55/15/23/5.
- Reader returns 30,5,29,1,64 (bad checksum) twice, then 30,5,29,1,65 → retry_cnt_o=2, done_o, outputs 30/5/29/1. The three rd_start_o pulses are spaced ≥100 cycles apart.
- No rd_valid_i at all → three starts, err_o after the third 50-cycle timeout, err_code_o=10, outputs keep their previous values.
- req_i pulsed three times during a busy transaction → exactly one extra transaction follows.
- Reset asserted in WAIT, with rd_valid_i in the same cycle → all outputs 0 and no done_o.
- With DHT_SCHED_AUTO_EN, AUTO_PERIOD_CYC=400, auto_en_i=1 → rd_start_o every 400 cycles. When auto_en_i drops → no further starts.
